bcd2bin: RTL and testbench

BCD2BIN -- requirements
Module: bcd2bin

---
 rtl/bcd2bin_pkg.sv | 29 ++
 rtl/bcd_digit_sub3.sv | 15 +
 rtl/bcd2bin.sv | 113 +++++++++++
 tb/tb_bcd2bin.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared definitions for the BCD-to-binary converter.
//   state_t       : converter FSM states
//   DIGIT_THRESH  : nibble value at or above which a correction applies
//   DIGIT_CORR    : correction subtracted from such a nibble
//   DIGIT_MAX     : largest legal BCD digit
//   bin_width()   : smallest binary width holding 10^digits-1
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0] DIGIT_THRESH = 4'd8;
    localparam logic [3:0] DIGIT_CORR   = 4'd3;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    function automatic int bin_width(input int digits);
        case (digits)
            1:       return 4;
            2:       return 7;
            3:       return 10;
            4:       return 14;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// bcd_digit_sub3: per-nibble correction for one reverse double-dabble step.
//   digit : nibble after the right shift
//   fixed : digit - 3 when digit >= 8, otherwise digit unchanged
module bcd_digit_sub3
    import bcd2bin_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    always_comb begin
        fixed = (digit >= DIGIT_THRESH) ? digit - DIGIT_CORR : digit;
    end

endmodule

// File: rtl/bcd2bin.sv
// bcd2bin: multi-cycle BCD-to-binary converter (reverse double dabble).
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : conversion request, sampled only in IDLE
//   bcd   : packed BCD digits, most significant digit in the top nibble
//   busy  : high in every state except IDLE
//   done  : one-cycle pulse marking bin/err valid
//   bin   : converted value, held until the next completion or reset
//   err   : last request contained a digit greater than 9
module bcd2bin
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = bin_width(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    localparam int WORK_W = 4*DIGITS + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   shifted;
    logic [WORK_W-1:0]   stepped;
    logic                bad_digit;

    // Working register: BCD digits on top, binary result accumulates below
    // as bits are shifted out of the BCD field.
    always_comb begin
        shifted = work >> 1;
    end

    assign stepped[BIN_W-1:0] = shifted[BIN_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .digit (shifted[BIN_W + 4*i +: 4]),
            .fixed (stepped[BIN_W + 4*i +: 4])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > DIGIT_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (bad_digit) begin
                            // Invalid digits bypass the shift loop entirely.
                            bin   <= '0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            work  <= {bcd, {BIN_W{1'b0}}};
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= stepped;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        // Result is taken from the post-step value so the
                        // final step does not cost an extra cycle.
                        bin   <= stepped[BIN_W-1:0];
                        err   <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: scoreboard bench for bcd2bin (3-digit and 4-digit builds).
// Stimulus pushes expected {bin, err, completion cycle, busy run}; monitors
// pop and compare on every done pulse.
module tb_bcd2bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic [9:0]  bin;
    logic        err;

    logic        start4;
    logic [15:0] bcd4;
    logic        busy4;
    logic        done4;
    logic [13:0] bin4;
    logic        err4;

    always #5 clk = ~clk;

    bcd2bin #(.DIGITS(3), .BIN_W(10)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    bcd2bin #(.DIGITS(4), .BIN_W(14)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .bcd   (bcd4),
        .busy  (busy4),
        .done  (done4),
        .bin   (bin4),
        .err   (err4)
    );

    typedef struct {
        int unsigned bin;
        int unsigned err;
        int unsigned due;
        int unsigned lat;
        int unsigned bcd;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];
    exp_t e3;
    exp_t e4;

    int unsigned cyc = 0;
    int n_total = 0;
    int n_pass  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Decimal to packed BCD; also serves as the 8-bit binary-to-BCD re-encoder.
    function automatic int unsigned to_bcd(input int unsigned v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic push3(input int unsigned v, input int unsigned b, input int unsigned er,
                         input int unsigned due);
        exp_t e;
        e.bin = b;
        e.err = er;
        e.due = due;
        e.lat = (er != 0) ? 1 : 11;
        e.bcd = v;
        q3.push_back(e);
    endtask

    // Called at a negedge: accept edge is cyc+1, done sampled at cyc+latency.
    task automatic issue3(input int unsigned v, input int unsigned b, input int unsigned er);
        push3(v, b, er, cyc + ((er != 0) ? 1 : 11));
        start = 1'b1;
        bcd   = 12'(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue4(input int unsigned v, input int unsigned b, input int unsigned er);
        exp_t e;
        e.bin = b;
        e.err = er;
        e.lat = (er != 0) ? 1 : 15;
        e.due = cyc + e.lat;
        e.bcd = v;
        q4.push_back(e);
        start4 = 1'b1;
        bcd4   = 16'(v);
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_idle3();
        int unsigned n = 0;
        while ((busy || done || q3.size() > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle3", 32'(n < 200), 1);
    endtask

    task automatic wait_idle4();
        int unsigned n = 0;
        while ((busy4 || done4 || q4.size() > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle4", 32'(n < 200), 1);
    endtask

    // Monitor for the 3-digit build.
    initial begin
        int unsigned run = 0;
        forever begin
            @(negedge clk);
            if (busy) run++;
            else run = 0;
            if (done) begin
                check("done3_expected", 32'(q3.size() > 0), 1);
                if (q3.size() > 0) begin
                    e3 = q3.pop_front();
                    check("bin3", 32'(bin), e3.bin);
                    check("err3", 32'(err), e3.err);
                    check("latency3", cyc, e3.due);
                    check("busy_cycles3", run, e3.lat);
                    if (e3.err == 0 && bin < 10'd256) begin
                        check("reencode8", to_bcd(32'(bin)), e3.bcd);
                    end
                end
            end
        end
    end

    // Monitor for the 4-digit build.
    initial begin
        int unsigned run = 0;
        forever begin
            @(negedge clk);
            if (busy4) run++;
            else run = 0;
            if (done4) begin
                check("done4_expected", 32'(q4.size() > 0), 1);
                if (q4.size() > 0) begin
                    e4 = q4.pop_front();
                    check("bin4", 32'(bin4), e4.bin);
                    check("err4", 32'(err4), e4.err);
                    check("latency4", cyc, e4.due);
                    check("busy_cycles4", run, e4.lat);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bcd    = '0;
        start4 = 1'b0;
        bcd4   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bin", 32'(bin), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy4", 32'(busy4), 0);
        check("rst_bin4", 32'(bin4), 0);

        // First start right after reset release, maximum input.
        rst = 1'b0;
        issue3(12'h999, 999, 0);
        wait_idle3();

        // Invalid digit, then err/bin hold, then a valid request clears err.
        issue3(12'h1A0, 0, 1);
        wait_idle3();
        repeat (2) begin
            @(negedge clk);
            check("hold_err1", 32'(err), 1);
            check("hold_bin0", 32'(bin), 0);
        end
        issue3(12'h042, 42, 0);
        wait_idle3();
        issue3(12'h000, 0, 0);
        wait_idle3();

        // Extra starts 3 and 6 cycles into a conversion, bcd changed meanwhile.
        issue3(12'h255, 255, 0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        bcd   = 12'h999;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle3();
        repeat (15) @(negedge clk);

        // Reset 5 cycles into a conversion, together with a start.
        start = 1'b1;
        bcd   = 12'h999;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bcd   = 12'h123;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_bin", 32'(bin), 0);
        check("abort_err", 32'(err), 0);
        rst = 1'b0;
        issue3(12'h007, 7, 0);
        wait_idle3();
        repeat (3) begin
            @(negedge clk);
            check("hold_bin7", 32'(bin), 7);
            check("hold_err0", 32'(err), 0);
        end

        // start held high: new conversion every 12 cycles.
        push3(12'h123, 123, 0, cyc + 11);
        push3(12'h123, 123, 0, cyc + 23);
        push3(12'h123, 123, 0, cyc + 35);
        start = 1'b1;
        bcd   = 12'h123;
        repeat (25) @(negedge clk);
        start = 1'b0;
        wait_idle3();

        // Back-to-back sweep of every 3-digit value.
        start = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            bcd = 12'(to_bcd(v));
            push3(to_bcd(v), v, 0, cyc + 11);
            repeat (12) @(negedge clk);
        end
        start = 1'b0;
        wait_idle3();

        // 4-digit build.
        issue4(16'h9999, 9999, 0);
        wait_idle4();
        issue4(16'h0000, 0, 0);
        wait_idle4();
        issue4(16'h12A4, 0, 1);
        wait_idle4();
        issue4(16'h1234, 1234, 0);
        wait_idle4();

        repeat (5) @(negedge clk);
        check("drained3", q3.size(), 0);
        check("drained4", q4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
